// File: rtl/store_buffer_lsu.sv
// ---------------------------------------------------------------------------
// store_buffer_lsu
//
// Load/store front-end placed directly in front of a single-port data memory
// (asynchronous read, synchronous write). Stores are absorbed into a small
// in-order FIFO and written back ("drained") in any cycle the memory port is
// not needed by a load. Loads are sent straight to memory and answered one
// cycle later. If the buffer holds a pending store to the same address, the
// youngest matching entry is returned instead of the memory contents.
//
// Optional feature (compile-time macro SB_COALESCE_EN):
//   When defined, a store to an address that already has a buffer entry
//   overwrites that entry's data in place. It is accepted even when the
//   buffer is full, unless the match is the head being drained in that same
//   cycle; in that case the store allocates normally. When the macro is not
//   defined, every store allocates a new entry and duplicates are allowed.
//
// Parameters:
//   DEPTH - store-buffer entries (power of 2, >= 2)
//   AW    - address width
//   DW    - data width
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - request handshake (loads are always ready)
//   req_we            - 1 = store, 0 = load
//   req_adr/req_wdata - request address / store data
//   resp_valid        - one-cycle pulse, one cycle after an accepted load
//   resp_data         - load result (forwarded or from memory)
//   sb_empty          - no pending stores (registered)
//   mem_adr/mem_datain/mem_w/mem_r - memory pins (combinational)
//   mem_dataout       - memory asynchronous read data
// ---------------------------------------------------------------------------
module store_buffer_lsu #(
   parameter int DEPTH = 4,
   parameter int AW    = 64,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_adr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_data,
   output logic          sb_empty,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_datain,
   output logic          mem_w,
   output logic          mem_r,
   input  logic [DW-1:0] mem_dataout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Entry storage and bookkeeping
   logic [AW-1:0]    adr_q   [DEPTH];
   logic [AW-1:0]    adr_d   [DEPTH];
   logic [DW-1:0]    data_q  [DEPTH];
   logic [DW-1:0]    data_d  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    head_d;
   logic [PW-1:0]    tail_q;
   logic [PW-1:0]    tail_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   // Registered outputs
   logic             resp_valid_q;
   logic             resp_valid_d;
   logic [DW-1:0]    resp_data_q;
   logic [DW-1:0]    resp_data_d;
   logic             sb_empty_q;
   logic             sb_empty_d;

   // Per-cycle control
   logic             load_acc;
   logic             drain;
   logic             store_acc;
   logic             store_alloc;
   logic             coal_hit;
   logic [PW-1:0]    coal_idx;
   logic [DEPTH-1:0] hit_vec;
   logic [DW-1:0]    fwd_data;
   logic [PW-1:0]    age_idx;

   // Address match against every valid entry, head included.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[gi] && (adr_q[gi] == req_adr);
   end

   // Forwarding: walk entries oldest to youngest starting at head so the last
   // match seen is the youngest. Valid entries are contiguous from head.
   always_comb begin
      fwd_data = mem_dataout;
      age_idx  = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         age_idx = head_q + PW'(i);
         if (hit_vec[age_idx]) begin
            fwd_data = data_q[age_idx];
         end
      end
   end

   // Port arbitration: an accepted load owns the memory port; otherwise the
   // head entry drains whenever one exists. Reset suppresses both.
   assign load_acc = !rst && req_valid && !req_we;
   assign drain    = !rst && !load_acc && (count_q != '0);

   // Coalescing target: a matching entry that is not leaving this cycle.
`ifdef SB_COALESCE_EN
   always_comb begin
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (hit_vec[i] && !(drain && (PW'(i) == head_q))) begin
            coal_hit = 1'b1;
            coal_idx = PW'(i);
         end
      end
   end
`else
   assign coal_hit = 1'b0;
   assign coal_idx = '0;
`endif

   // No enqueue-on-drain when full: the full check uses the current count.
   assign req_ready   = req_we ? (coal_hit || (count_q != FULL)) : 1'b1;
   assign store_acc   = !rst && req_valid && req_we && req_ready;
   assign store_alloc = store_acc && !coal_hit;

   // Memory pins; all zero when the port is idle.
   always_comb begin
      mem_r      = load_acc;
      mem_w      = drain;
      mem_adr    = '0;
      mem_datain = '0;
      if (load_acc) begin
         mem_adr = req_adr;
      end else if (drain) begin
         mem_adr    = adr_q[head_q];
         mem_datain = data_q[head_q];
      end
   end

   // Next-state for FIFO and registered outputs
   always_comb begin
      adr_d   = adr_q;
      data_d  = data_q;
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (store_alloc) begin
         adr_d[tail_q]   = req_adr;
         data_d[tail_q]  = req_wdata;
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PW'(1);
      end
      if (store_acc && coal_hit) begin
         data_d[coal_idx] = req_wdata;
      end
      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end

      case ({store_alloc, drain})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      resp_valid_d = load_acc;
      resp_data_d  = load_acc ? fwd_data : resp_data_q;
      sb_empty_d   = (count_d == '0);
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         sb_empty_q   <= 1'b1;
      end else begin
         valid_q      <= valid_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         sb_empty_q   <= sb_empty_d;
      end
   end

   // Entry payload needs no reset: it is only observed through valid bits.
   always_ff @(posedge clk) begin
      adr_q  <= adr_d;
      data_q <= data_d;
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign sb_empty   = sb_empty_q;

endmodule

// File: tb/tb_store_buffer_lsu.sv
// ---------------------------------------------------------------------------
// tb_store_buffer_lsu
//
// Bench for store_buffer_lsu with a 256-entry memory model (initial value 1,
// async read, sync write). Each cycle is checked against a queue-based
// reference model; a table of directed cycles additionally carries
// hand-derived expected values, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_store_buffer_lsu;

   localparam int DEPTH = 4;
   localparam int AW    = 64;
   localparam int DW    = 64;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_adr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic          sb_empty;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_datain;
   logic          mem_w;
   logic          mem_r;
   logic [DW-1:0] mem_dataout;

   store_buffer_lsu #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_adr     (req_adr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .sb_empty    (sb_empty),
      .mem_adr     (mem_adr),
      .mem_datain  (mem_datain),
      .mem_w       (mem_w),
      .mem_r       (mem_r),
      .mem_dataout (mem_dataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: every word starts at 1.
   logic [DW-1:0] mem [256] = '{default: 64'd1};
   always @(posedge clk) begin
      if (mem_w) mem[mem_adr[7:0]] <= mem_datain;
   end
   assign mem_dataout = mem[mem_adr[7:0]];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO of pending stores plus a shadow memory.
   typedef struct {
      logic [63:0] adr;
      logic [63:0] data;
   } ent_t;
   ent_t        sbq[$];
   logic [63:0] ref_mem [256];

   // Values sampled during the last cycle, for the directed table.
   logic        s_ready, s_mem_r, s_mem_w, s_rv, s_empty;
   logic [63:0] s_mem_adr, s_rd;

   task automatic cycle(input logic r, input logic v, input logic we,
                        input logic [63:0] adr, input logic [63:0] wd);
      logic        load, drain, e_ready, store_acc, coal;
      int          coal_i;
      logic [63:0] e_adr, e_din, fwd;
      ent_t        hd;
      ent_t        ne;

      @(negedge clk);
      rst = r; req_valid = v; req_we = we; req_adr = adr; req_wdata = wd;
      #1;

      load  = !r && v && !we;
      drain = !r && !load && (sbq.size() > 0);
      coal  = 1'b0;
      coal_i = 0;
`ifdef SB_COALESCE_EN
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].adr == adr && !(drain && i == 0)) begin
            coal = 1'b1;
            coal_i = i;
         end
      end
`endif
      e_ready = we ? (coal || sbq.size() < DEPTH) : 1'b1;
      e_adr = 64'd0;
      e_din = 64'd0;
      if (load) e_adr = adr;
      else if (drain) begin
         e_adr = sbq[0].adr;
         e_din = sbq[0].data;
      end
      fwd = ref_mem[adr[7:0]];
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].adr == adr) fwd = sbq[i].data;
      end

      s_ready = req_ready; s_mem_r = mem_r; s_mem_w = mem_w; s_mem_adr = mem_adr;
      chk("req_ready", {63'd0, req_ready}, {63'd0, e_ready});
      chk("mem_r", {63'd0, mem_r}, {63'd0, load});
      chk("mem_w", {63'd0, mem_w}, {63'd0, drain});
      chk("mem_adr", mem_adr, e_adr);
      chk("mem_datain", mem_datain, e_din);

      if (r) begin
         sbq.delete();
      end else begin
         store_acc = v && we && e_ready;
         if (store_acc) begin
            if (coal) sbq[coal_i].data = wd;
            else begin
               ne.adr = adr;
               ne.data = wd;
               sbq.push_back(ne);
            end
         end
         if (drain) begin
            hd = sbq.pop_front();
            ref_mem[hd.adr[7:0]] = hd.data;
         end
      end

      @(posedge clk);
      #1;
      s_rv = resp_valid; s_rd = resp_data; s_empty = sb_empty;
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, load});
      if (load) chk("resp_data", resp_data, fwd);
      if (r) chk("resp_data_rst", resp_data, 64'd0);
      chk("sb_empty", {63'd0, sb_empty}, {63'd0, (sbq.size() == 0)});
      $display("txn t=%0t rst=%0d v=%0d we=%0d adr=%0h wd=%0h rv=%0d rd=%0h pend=%0d",
               $time, r, v, we, adr, wd, resp_valid, resp_data, sbq.size());
   endtask

   typedef struct {
      logic        r, v, we;
      logic [63:0] adr, wd;
      logic        ready, mr, mw;
      logic [63:0] madr;
      logic        rv;
      logic [63:0] rd;
      logic        empty;
   } vec_t;

   function automatic vec_t mk(logic r, logic v, logic we, logic [63:0] adr, logic [63:0] wd,
                               logic ready, logic mr, logic mw, logic [63:0] madr,
                               logic rv, logic [63:0] rd, logic empty);
      vec_t t;
      t.r = r; t.v = v; t.we = we; t.adr = adr; t.wd = wd;
      t.ready = ready; t.mr = mr; t.mw = mw; t.madr = madr;
      t.rv = rv; t.rd = rd; t.empty = empty;
      return t;
   endfunction

   vec_t vt [24];

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 64'd1;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;

      //             r  v  we adr   wd      rdy mr mw madr  rv rd     empty
      vt[0]  = mk(1, 0, 0, 0,    0,      1,  0, 0, 0,    0, 0,     1); // reset
      vt[1]  = mk(0, 1, 0, 5,    0,      1,  1, 0, 5,    1, 1,     1); // load init value
      vt[2]  = mk(0, 1, 1, 3,    'hAA,   1,  0, 0, 0,    0, 0,     0); // store 3
      vt[3]  = mk(0, 1, 0, 3,    0,      1,  1, 0, 3,    1, 'hAA,  0); // forward, no drain
      vt[4]  = mk(0, 0, 0, 0,    0,      1,  0, 1, 3,    0, 0,     1); // drain 3
      vt[5]  = mk(0, 1, 0, 3,    0,      1,  1, 0, 3,    1, 'hAA,  1); // memory now holds it
      vt[6]  = mk(0, 1, 1, 10,   'h10,   1,  0, 0, 0,    0, 0,     0);
      vt[7]  = mk(0, 1, 0, 20,   0,      1,  1, 0, 20,   1, 1,     0);
      vt[8]  = mk(0, 1, 1, 11,   'h11,   1,  0, 1, 10,   0, 0,     0); // store + drain
      vt[9]  = mk(0, 1, 0, 21,   0,      1,  1, 0, 21,   1, 1,     0);
      vt[10] = mk(0, 1, 1, 12,   'h12,   1,  0, 1, 11,   0, 0,     0);
      vt[11] = mk(0, 1, 1, 13,   'h13,   1,  0, 1, 12,   0, 0,     0);
      vt[12] = mk(0, 0, 0, 0,    0,      1,  0, 1, 13,   0, 0,     1);
      vt[13] = mk(0, 1, 0, 10,   0,      1,  1, 0, 10,   1, 'h10,  1);
      vt[14] = mk(0, 1, 0, 13,   0,      1,  1, 0, 13,   1, 'h13,  1);
      vt[15] = mk(0, 1, 1, 7,    1,      1,  0, 0, 0,    0, 0,     0); // 7 = 1
      vt[16] = mk(0, 1, 1, 7,    2,      1,  0, 1, 7,    0, 0,     0); // 7 = 2, drains 7 = 1
      vt[17] = mk(0, 1, 0, 7,    0,      1,  1, 0, 7,    1, 2,     0); // youngest forwarded
      vt[18] = mk(0, 0, 0, 0,    0,      1,  0, 1, 7,    0, 0,     1); // second drain
      vt[19] = mk(0, 1, 0, 7,    0,      1,  1, 0, 7,    1, 2,     1);
      vt[20] = mk(0, 1, 1, 30,   'h55,   1,  0, 0, 0,    0, 0,     0); // pending store
      vt[21] = mk(1, 0, 0, 0,    0,      1,  0, 0, 0,    0, 0,     1); // reset: no write
      vt[22] = mk(0, 1, 0, 30,   0,      1,  1, 0, 30,   1, 1,     1); // store was discarded
      vt[23] = mk(0, 0, 0, 0,    0,      1,  0, 0, 0,    0, 0,     1); // idle port

      for (int i = 0; i < 24; i++) begin
         cycle(vt[i].r, vt[i].v, vt[i].we, vt[i].adr, vt[i].wd);
         chk($sformatf("vec%0d ready", i), {63'd0, s_ready}, {63'd0, vt[i].ready});
         chk($sformatf("vec%0d mem_r", i), {63'd0, s_mem_r}, {63'd0, vt[i].mr});
         chk($sformatf("vec%0d mem_w", i), {63'd0, s_mem_w}, {63'd0, vt[i].mw});
         chk($sformatf("vec%0d mem_adr", i), s_mem_adr, vt[i].madr);
         chk($sformatf("vec%0d resp_valid", i), {63'd0, s_rv}, {63'd0, vt[i].rv});
         if (vt[i].rv || vt[i].r)
            chk($sformatf("vec%0d resp_data", i), s_rd, vt[i].rd);
         chk($sformatf("vec%0d sb_empty", i), {63'd0, s_empty}, {63'd0, vt[i].empty});
      end

      // Pointer wrap: ten stores separated by idle cycles, then read back.
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 1, 64'(40 + i), 64'(64'h100 + i));
         cycle(0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 0, 64'(40 + i), 0);
         chk($sformatf("wrap rd%0d", i), s_rd, 64'(64'h100 + i));
      end

      // Randomized traffic over a small address window to exercise forwarding.
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               $urandom_range(0, 1) == 1, 64'($urandom_range(0, 15)),
               {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
